// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared mode encodings and width helper for the N:1 registered mux
package mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - rotating-priority picker: first request strictly after base, wrapping
module rr_pick #(
    parameter int N_CH  = 4,
    parameter int SEL_W = 2
) (
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] base,
    output logic [N_CH-1:0]  gnt,
    output logic [SEL_W-1:0] idx,
    output logic             any
);

    int               k;
    logic [SEL_W-1:0] kk;

    // Search base+1 .. base+N_CH so the channel at base itself has lowest priority.
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        k   = 0;
        kk  = '0;
        for (int i = 1; i <= N_CH; i++) begin
            k = int'(base) + i;
            if (k >= N_CH) begin
                k = k - N_CH;
            end
            kk = SEL_W'(k);
            if (!any && req[kk]) begin
                any     = 1'b1;
                gnt[kk] = 1'b1;
                idx     = kk;
            end
        end
    end

endmodule

// File: rtl/mux_nx1_arb.sv
// rtl/mux_nx1_arb.sv - N:1 registered mux with fixed-select or round-robin grant
module mux_nx1_arb
    import mux_pkg::*;
#(
    parameter  int N_CH   = 4,
    parameter  int DATA_W = 8,
    localparam int SEL_W  = clog2(N_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mode,
    input  logic [SEL_W-1:0]         sel,
    input  logic [N_CH-1:0]          in_valid,
    input  logic [N_CH*DATA_W-1:0]   in_data,
    output logic [N_CH-1:0]          in_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic [SEL_W-1:0]         out_ch,
    input  logic                     out_ready
);

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0]  out_ch_q, out_ch_d;
    logic [SEL_W-1:0]  rr_ptr_q, rr_ptr_d;

    logic [N_CH-1:0]   fixed_req;
    logic [N_CH-1:0]   pick_req;
    logic [N_CH-1:0]   gnt;
    logic [SEL_W-1:0]  gnt_idx;
    logic              gnt_any;
    logic              load_en;
    logic              xfer;

    // Fixed mode reuses the picker with a single-bit request; out-of-range sel masks to zero.
    always_comb begin
        fixed_req = '0;
        for (int k = 0; k < N_CH; k++) begin
            fixed_req[k] = in_valid[k] && (sel == SEL_W'(k));
        end
    end

    assign pick_req = (mode == MODE_RR) ? in_valid : fixed_req;

    rr_pick #(
        .N_CH  (N_CH),
        .SEL_W (SEL_W)
    ) u_pick (
        .req  (pick_req),
        .base (rr_ptr_q),
        .gnt  (gnt),
        .idx  (gnt_idx),
        .any  (gnt_any)
    );

    assign load_en  = !out_valid_q || out_ready;
    assign in_ready = gnt & {N_CH{load_en && !rst}};
    assign xfer     = gnt_any && load_en && !rst;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        rr_ptr_d    = rr_ptr_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = in_data[int'(gnt_idx)*DATA_W +: DATA_W];
            out_ch_d    = gnt_idx;
            if (mode == MODE_RR) begin
                rr_ptr_d = gnt_idx;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Pointer resets to the last channel so channel 0 wins the first round-robin grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            rr_ptr_q    <= SEL_W'(N_CH - 1);
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_mux_nx1_arb.sv
// tb/tb_mux_nx1_arb.sv - randomized and directed checks of mux_nx1_arb against a behavioural model
module tb_mux_nx1_arb;

    localparam int N  = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          mode;
    logic [1:0]    sel;
    logic [N-1:0]  in_valid;
    logic [N*DW-1:0] in_data;
    logic [N-1:0]  in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [1:0]    out_ch;
    logic          out_ready;

    int tests = 0;
    int fails = 0;

    // behavioural model state
    bit     m_valid;
    int     m_data;
    int     m_ch;
    int     m_ptr;
    bit     chk_en = 0;
    int     ch_seq[$];

    mux_nx1_arb #(.N_CH(N), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Which channel the rules say wins now, or -1.
    function automatic int model_grant();
        if (mode == 1'b0) begin
            if (int'(sel) < N && in_valid[sel]) return int'(sel);
            return -1;
        end
        for (int i = 1; i <= N; i++) begin
            if (in_valid[(m_ptr + i) % N]) return (m_ptr + i) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] model_ready();
        int g;
        g = model_grant();
        if (rst || g < 0 || (m_valid && !out_ready)) return '0;
        return N'(1 << g);
    endfunction

    always @(posedge clk) begin
        int g;
        if (rst) begin
            m_valid = 0; m_data = 0; m_ch = 0; m_ptr = N - 1;
        end else begin
            g = model_grant();
            if (g >= 0 && (!m_valid || out_ready)) begin
                m_valid = 1;
                m_data  = int'(in_data[g*DW +: DW]);
                m_ch    = g;
                if (mode) m_ptr = g;
            end else if (out_ready) begin
                m_valid = 0;
            end
        end
        chk_en = 1;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model in_ready", 32'(in_ready), 32'(model_ready()));
            check("model out_valid", 32'(out_valid), 32'(m_valid));
            check("model out_data", 32'(out_data), 32'(m_data));
            check("model out_ch", 32'(out_ch), 32'(m_ch));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int k, input logic [DW-1:0] v);
        in_data[k*DW +: DW] = v;
    endtask

    initial begin
        rst = 1; mode = 1; sel = 0; in_valid = 4'hF; out_ready = 1;
        in_data = 32'h44332211;

        // reset
        tick();
        check("rst in_ready", 32'(in_ready), 32'h0);
        check("rst out_valid", 32'(out_valid), 32'h0);
        check("rst out_data", 32'(out_data), 32'h0);
        check("rst out_ch", 32'(out_ch), 32'h0);
        tick();
        rst = 0; #1;
        check("first rr grant", 32'(in_ready), 32'h1);

        // fixed select
        mode = 0; sel = 2; in_valid = 4'b0101; set_ch(2, 8'hA5); #1;
        check("fixed in_ready", 32'(in_ready), 32'h4);
        tick();
        check("fixed out_valid", 32'(out_valid), 32'h1);
        check("fixed out_data", 32'(out_data), 32'hA5);
        check("fixed out_ch", 32'(out_ch), 32'h2);
        sel = 1; #1;
        check("fixed idle in_ready", 32'(in_ready), 32'h0);
        tick();
        check("fixed idle out_valid", 32'(out_valid), 32'h0);

        // round-robin fairness
        mode = 1; in_valid = 4'hF;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("rr valid", 32'(out_valid), 32'h1);
            ch_seq.push_back(int'(out_ch));
        end
        for (int i = 0; i < 8; i++) check("rr seq", 32'(ch_seq[i]), 32'(i % 4));

        // backpressure
        in_valid = 4'b0010; set_ch(1, 8'h3C);
        tick();
        check("bp load ch", 32'(out_ch), 32'h1);
        out_ready = 0; in_valid = 4'hF;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp in_ready", 32'(in_ready), 32'h0);
            tick();
            check("bp out_data", 32'(out_data), 32'h3C);
            check("bp out_ch", 32'(out_ch), 32'h1);
            check("bp out_valid", 32'(out_valid), 32'h1);
        end
        out_ready = 1; #1;
        check("bp resume in_ready", 32'(in_ready), 32'h4);
        tick();
        check("bp no bubble", 32'(out_ch), 32'h2);

        // sparse / wrap
        in_valid = 4'b1000; tick();
        in_valid = 4'b1001; #1;
        check("wrap in_ready", 32'(in_ready), 32'h1);
        tick();
        check("wrap out_ch0", 32'(out_ch), 32'h0);
        in_valid = 4'b1000; #1;
        check("sparse in_ready", 32'(in_ready), 32'h8);
        tick();
        check("sparse out_ch3", 32'(out_ch), 32'h3);

        // reset mid-operation while stalled
        out_ready = 0; in_valid = 4'h0; tick();
        check("stall held", 32'(out_valid), 32'h1);
        rst = 1; tick();
        check("midrst out_valid", 32'(out_valid), 32'h0);
        rst = 0; out_ready = 1; tick();
        check("midrst discarded", 32'(out_valid), 32'h0);
        in_valid = 4'hF; #1;
        check("midrst ptr", 32'(in_ready), 32'h1);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            rst       = ($urandom_range(0, 99) == 0);
            mode      = 1'($urandom_range(0, 3) != 0);
            sel       = 2'($urandom);
            in_valid  = 4'($urandom);
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
        end
        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
